// File: rtl/conveyor_read_tracker_pkg.sv
// conveyor_read_tracker_pkg: widths, fault codes and entry/fill records shared by the read tracker
package conveyor_read_tracker_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int CONVEYOR_ADDR_WIDTH = 4;
  localparam int FAULT_ADDR_WIDTH = 3;
  localparam int QUEUE_ADDR_WIDTH = 2;
  typedef enum logic [FAULT_ADDR_WIDTH-1:0] {
    F_NONE = 3'd0,
    F_BUS  = 3'd1
  } fault_t;
  typedef struct packed {
    logic [WORD_WIDTH-1:0]          addr;
    logic                           conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] slot;
  } entry_t;
  typedef struct packed {
    logic                           conveyor;
    logic [CONVEYOR_ADDR_WIDTH-1:0] slot;
    logic [WORD_WIDTH-1:0]          data;
    fault_t                         fault;
  } fill_t;
endpackage

// File: rtl/conveyor_read_tracker_queue.sv
// tracker_queue: circular entry store with tail/issue/head pointers and count/pending counters
//   push/push_entry   : allocate an entry at tail
//   issue/issue_entry : entry at the issue pointer, advanced when its command is taken
//   retire/head_entry : oldest issued entry, advanced when its response returns
//   full, pending_any, outstanding_any, busy : registered occupancy status
module tracker_queue
  import conveyor_read_tracker_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   issue,
  input  logic   retire,
  output entry_t issue_entry,
  output entry_t head_entry,
  output logic   full,
  output logic   pending_any,
  output logic   outstanding_any,
  output logic   busy
);
  localparam int DEPTH = 1 << QUEUE_ADDR_WIDTH;
  entry_t mem [DEPTH];
  logic [QUEUE_ADDR_WIDTH-1:0] tail, issue_ptr, head;
  logic [QUEUE_ADDR_WIDTH:0] count, pending;
  assign issue_entry = mem[issue_ptr];
  assign head_entry = mem[head];
  assign full = count == (QUEUE_ADDR_WIDTH+1)'(DEPTH);
  assign pending_any = pending != '0;
  assign outstanding_any = count != pending;
  assign busy = count != '0;
  always_ff @(posedge clk)
    if (push) mem[tail] <= push_entry;
  always_ff @(posedge clk)
    if (reset) begin
      tail <= '0;
      issue_ptr <= '0;
      head <= '0;
      count <= '0;
      pending <= '0;
    end else begin
      tail <= tail + QUEUE_ADDR_WIDTH'(push);
      issue_ptr <= issue_ptr + QUEUE_ADDR_WIDTH'(issue);
      head <= head + QUEUE_ADDR_WIDTH'(retire);
      count <= count + (QUEUE_ADDR_WIDTH+1)'(push) - (QUEUE_ADDR_WIDTH+1)'(retire);
      pending <= pending + (QUEUE_ADDR_WIDTH+1)'(push) - (QUEUE_ADDR_WIDTH+1)'(issue);
    end
endmodule

// File: rtl/conveyor_read_tracker.sv
// conveyor_read_tracker: issues tagged reads in order and turns in-order responses into conveyor slot fills
//   req_*      : tagged read requests from the core (req_ready from registered occupancy only)
//   mem_rd_*   : read command port, held stable while stalled
//   mem_resp_* : in-order read responses, no backpressure
//   fill_*     : one registered slot write per response, data plus fault code
//   busy       : any entry allocated; stray_resp : response arrived with nothing issued
module conveyor_read_tracker
  import conveyor_read_tracker_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [WORD_WIDTH-1:0]          req_addr,
  input  logic                           req_conveyor,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] req_slot,
  output logic                           req_ready,
  output logic                           mem_rd_valid,
  output logic [WORD_WIDTH-1:0]          mem_rd_addr,
  input  logic                           mem_rd_ready,
  input  logic                           mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]          mem_resp_data,
  input  logic                           mem_resp_error,
  output logic                           fill_valid,
  output logic                           fill_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] fill_slot,
  output logic [WORD_WIDTH-1:0]          fill_data,
  output logic [FAULT_ADDR_WIDTH-1:0]    fill_fault,
  output logic                           busy,
  output logic                           stray_resp
);
  entry_t issue_entry, head_entry;
  fill_t fill_q;
  logic full, pending_any, outstanding_any, push, issue, retire;
  assign push = req_valid && req_ready;
  assign issue = mem_rd_valid && mem_rd_ready;
  // a command taken this cycle may be answered in the same cycle by a zero-latency memory
  assign retire = mem_resp_valid && (outstanding_any || issue);
  assign req_ready = !full;
  assign mem_rd_valid = pending_any;
  assign mem_rd_addr = pending_any ? issue_entry.addr : '0;
  tracker_queue u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_entry('{addr: req_addr, conveyor: req_conveyor, slot: req_slot}),
    .issue(issue),
    .retire(retire),
    .issue_entry(issue_entry),
    .head_entry(head_entry),
    .full(full),
    .pending_any(pending_any),
    .outstanding_any(outstanding_any),
    .busy(busy)
  );
  always_ff @(posedge clk)
    if (reset) begin
      fill_valid <= 1'b0;
      stray_resp <= 1'b0;
      fill_q <= '0;
    end else begin
      fill_valid <= retire;
      stray_resp <= mem_resp_valid && !retire;
      if (retire) fill_q <= '{conveyor: head_entry.conveyor, slot: head_entry.slot, data: mem_resp_data, fault: mem_resp_error ? F_BUS : F_NONE};
    end
  assign fill_conveyor = fill_q.conveyor;
  assign fill_slot = fill_q.slot;
  assign fill_data = fill_q.data;
  assign fill_fault = fill_q.fault;
endmodule

// File: tb/tb_conveyor_read_tracker.sv
// tb_conveyor_read_tracker: directed scoreboard bench for conveyor_read_tracker
module tb_conveyor_read_tracker;
  import conveyor_read_tracker_pkg::*;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_conveyor = 0, req_ready;
  logic [31:0] req_addr = 0;
  logic [3:0] req_slot = 0;
  logic mem_rd_valid, mem_rd_ready = 0;
  logic [31:0] mem_rd_addr;
  logic mem_resp_valid = 0, mem_resp_error = 0;
  logic [31:0] mem_resp_data = 0;
  logic fill_valid, fill_conveyor, busy, stray_resp;
  logic [3:0] fill_slot;
  logic [31:0] fill_data;
  logic [2:0] fill_fault;
  int checks = 0, errors = 0;
  typedef struct {logic conv; logic [3:0] slot;} tag_t;
  typedef struct {logic conv; logic [3:0] slot; logic [31:0] data; logic [2:0] fault;} exp_t;
  tag_t tq[$];
  exp_t exp_q[$];

  conveyor_read_tracker dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_conveyor(req_conveyor), .req_slot(req_slot), .req_ready(req_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_ready(mem_rd_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
    .fill_valid(fill_valid), .fill_conveyor(fill_conveyor), .fill_slot(fill_slot), .fill_data(fill_data),
    .fill_fault(fill_fault), .busy(busy), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic c, input logic [3:0] s);
    req_valid = 1; req_addr = a; req_conveyor = c; req_slot = s;
    tq.push_back('{c, s});
    step;
    req_valid = 0;
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    tag_t t;
    t = tq.pop_front();
    exp_q.push_back('{t.conv, t.slot, d, e ? F_BUS : F_NONE});
    mem_resp_valid = 1; mem_resp_data = d; mem_resp_error = e;
    step;
    mem_resp_valid = 0; mem_resp_error = 0;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_rd_valid"}, mem_rd_valid, 0);
    chk({p, "_rd_addr"}, mem_rd_addr, 0);
    chk({p, "_fill_valid"}, fill_valid, 0);
    chk({p, "_fill_conv"}, fill_conveyor, 0);
    chk({p, "_fill_slot"}, fill_slot, 0);
    chk({p, "_fill_data"}, fill_data, 0);
    chk({p, "_fill_fault"}, fill_fault, F_NONE);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_stray"}, stray_resp, 0);
  endtask

  always @(negedge clk)
    if (!reset && fill_valid) begin
      chk("fill_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("fill_conv", fill_conveyor, x.conv);
        chk("fill_slot", fill_slot, x.slot);
        chk("fill_data", fill_data, x.data);
        chk("fill_fault", fill_fault, x.fault);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step; step;
    check_idle("reset");
    reset = 0;
    step;
    // single read
    mem_rd_ready = 1;
    req(32'h100, 0, 4'd15);
    chk("single_rd_valid", mem_rd_valid, 1);
    chk("single_rd_addr", mem_rd_addr, 32'h100);
    chk("single_busy", busy, 1);
    step; step;
    resp(32'hDEADBEEF, 0);
    chk("single_fill_valid", fill_valid, 1);
    step;
    chk("single_fill_one_cycle", fill_valid, 0);
    chk("single_idle", busy, 0);
    // fill to capacity
    mem_rd_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("cap_ready_before", req_ready, 1);
      req(32'h200 + 32'(i * 16), i[0], 4'(i + 1));
    end
    chk("cap_ready_full", req_ready, 0);
    chk("cap_rd_addr_stall", mem_rd_addr, 32'h200);
    req_valid = 1; req_addr = 32'h240; req_conveyor = 1; req_slot = 4'd5;
    step; step;
    chk("cap_fifth_held", req_ready, 0);
    chk("cap_rd_addr_stable", mem_rd_addr, 32'h200);
    mem_rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("cap_rd_valid", mem_rd_valid, 1);
      chk("cap_rd_addr", mem_rd_addr, 32'h200 + 32'(i * 16));
      step;
    end
    chk("cap_rd_drained", mem_rd_valid, 0);
    chk("cap_ready_still_full", req_ready, 0);
    resp(32'h1111, 0);
    chk("cap_ready_after_resp", req_ready, 1);
    tq.push_back('{1'b1, 4'd5});
    step;
    req_valid = 0;
    chk("cap_fifth_rd_addr", mem_rd_addr, 32'h240);
    resp(32'h2222, 0);
    resp(32'h3333, 0);
    resp(32'h4444, 0);
    resp(32'h5555, 0);
    step; step;
    chk("cap_idle", busy, 0);
    // ordering and tags
    req(32'h300, 0, 4'd3);
    req(32'h304, 1, 4'd9);
    req(32'h308, 0, 4'd2);
    step; step;
    resp(32'hAAAA0001, 0);
    chk("ord_fill_a", fill_valid, 1);
    resp(32'hBBBB0002, 0);
    chk("ord_fill_b", fill_valid, 1);
    resp(32'hCCCC0003, 0);
    chk("ord_fill_c", fill_valid, 1);
    step;
    chk("ord_idle", busy, 0);
    // bus error
    req(32'h400, 1, 4'd7);
    step;
    resp(32'h55, 1);
    chk("err_fill_valid", fill_valid, 1);
    step;
    // zero-latency memory: response in the command cycle
    req(32'h500, 0, 4'd1);
    resp(32'h600D, 0);
    chk("zlat_fill_valid", fill_valid, 1);
    chk("zlat_no_stray", stray_resp, 0);
    step;
    // stray response
    chk("stray_pre_idle", busy, 0);
    mem_resp_valid = 1; mem_resp_data = 32'hBAD;
    step;
    mem_resp_valid = 0;
    chk("stray_pulse", stray_resp, 1);
    chk("stray_no_fill", fill_valid, 0);
    chk("stray_busy", busy, 0);
    step;
    chk("stray_one_cycle", stray_resp, 0);
    // mid-flight reset
    req(32'h700, 0, 4'd4);
    req(32'h710, 1, 4'd5);
    req(32'h720, 0, 4'd6);
    step;
    chk("rst_busy_before", busy, 1);
    reset = 1;
    step;
    reset = 0;
    tq.delete();
    check_idle("midrst");
    mem_resp_valid = 1; mem_resp_data = 32'h777;
    step;
    mem_resp_valid = 0;
    chk("midrst_stray", stray_resp, 1);
    chk("midrst_no_fill", fill_valid, 0);
    step; step;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
